// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU.
//   mbu_state_t : memory bus unit FSM state encoding
//   WORD_W      : datapath word width
package cpu_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        MBU_IDLE = 2'd0,
        MBU_BUSY = 2'd1,
        MBU_DONE = 2'd2
    } mbu_state_t;

endpackage

// File: rtl/mem_bus_unit.sv
// Memory-side stage of the multi-cycle CPU. It takes the controller's
// MemRead/MemWrite/IRWrite/IorD strobes, runs one req/ack access against a
// variable-latency memory and captures read data into IR or MDR. mem_stall
// holds the controller while an access is pending.
//
// Ports
//   clk, reset                   clock, synchronous active-low reset
//   MemRead, MemWrite            controller strobes (level)
//   IRWrite                      read destination: 1 = IR, 0 = MDR
//   IorD                         address select: 0 = PC, 1 = ALUOut
//   PC, ALUOut, WriteData        address sources and store data
//   mem_stall                    controller must hold state while high
//   Instruction, MemData         IR and MDR contents
//   bus_err                      sticky error (conflict, misalignment, timeout)
//   mem_req/we/addr/wdata        registered memory request
//   mem_rdata, mem_ack           memory response (ack is a one-cycle pulse)
module mem_bus_unit
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              IRWrite,
    input  logic              IorD,
    input  logic [WORD_W-1:0] PC,
    input  logic [WORD_W-1:0] ALUOut,
    input  logic [WORD_W-1:0] WriteData,
    output logic              mem_stall,
    output logic [WORD_W-1:0] Instruction,
    output logic [WORD_W-1:0] MemData,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    mbu_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic              dst_reg;

    logic              command;
    logic              conflict;
    logic              aligned;
    logic              issue;
    logic              timeout_hit;
    logic [WORD_W-1:0] sel_addr;

    assign command     = MemRead ^ MemWrite;
    assign conflict    = MemRead & MemWrite;
    assign sel_addr    = IorD ? ALUOut : PC;
    assign aligned     = (sel_addr[1:0] == 2'b00);
    assign issue       = command & aligned;
    assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));

    // Combinational so the controller freezes in the very cycle it issues.
    assign mem_stall = ((state_reg == MBU_IDLE) & issue) | (state_reg == MBU_BUSY);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= MBU_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MBU_IDLE: if (issue) state_next = MBU_BUSY;
            MBU_BUSY: if (mem_ack || timeout_hit) state_next = MBU_DONE;
            MBU_DONE: state_next = MBU_IDLE;
            default:  state_next = MBU_IDLE;
        endcase
    end

    // Datapath registers: request outputs, timeout counter, IR/MDR, error flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            dst_reg     <= 1'b0;
            cnt_reg     <= '0;
            Instruction <= '0;
            MemData     <= '0;
            bus_err     <= 1'b0;
        end else begin
            case (state_reg)
                MBU_IDLE: begin
                    if (conflict || (command && !aligned)) begin
                        bus_err <= 1'b1;
                    end else if (issue) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MemWrite;
                        mem_addr  <= sel_addr;
                        mem_wdata <= WriteData;
                        dst_reg   <= IRWrite;
                        cnt_reg   <= '0;
                    end
                end
                MBU_BUSY: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (!mem_we) begin
                            if (dst_reg) Instruction <= mem_rdata;
                            else         MemData     <= mem_rdata;
                        end
                    end else if (timeout_hit) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        bus_err <= 1'b1;
                    end
                end
                MBU_DONE: begin
                    cnt_reg <= '0;
                end
                default: begin
                    cnt_reg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_unit.sv
// Randomized self-checking bench for mem_bus_unit. A transaction-level model
// tracks IR, MDR and the error flag and predicts the stall length of each
// access from the ack latency.
module tb_mem_bus_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite, IRWrite, IorD;
    logic [31:0] PC, ALUOut, WriteData;
    logic        mem_stall;
    logic [31:0] Instruction, MemData;
    logic        bus_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_ir;
    logic [31:0] exp_mdr;
    logic        exp_err;

    localparam int TO = 16;

    mem_bus_unit #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .IorD       (IorD),
        .PC         (PC),
        .ALUOut     (ALUOut),
        .WriteData  (WriteData),
        .mem_stall  (mem_stall),
        .Instruction(Instruction),
        .MemData    (MemData),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One controller request. ack_k: BUSY cycle in which ack arrives (0 = never).
    // hold: keep the strobes high through DONE and into the following IDLE.
    task automatic run_access(input bit rd, input bit wr, input bit irw, input bit iord,
                              input logic [31:0] pc, input logic [31:0] alu,
                              input logic [31:0] wd, input int ack_k,
                              input logic [31:0] rdata, input bit hold);
        logic [31:0] addr;
        int          stall_cnt;
        int          exp_stall;
        int          c;
        addr = iord ? alu : pc;
        MemRead = rd; MemWrite = wr; IRWrite = irw; IorD = iord;
        PC = pc; ALUOut = alu; WriteData = wd;
        #1;
        if ((rd == wr) || (addr[1:0] != 2'b00)) begin
            if (rd || wr) exp_err = 1'b1;
            check_val("reject_stall", mem_stall, 0);
            tick();
            check_val("reject_req", mem_req, 0);
            check_val("reject_err", bus_err, exp_err);
            MemRead = 0; MemWrite = 0;
            $display("txn rd=%0b wr=%0b addr=%h rejected err=%0b", rd, wr, addr, bus_err);
            return;
        end
        check_val("issue_stall", mem_stall, 1);
        tick();
        check_val("busy_req", mem_req, 1);
        check_val("busy_we", mem_we, wr);
        check_val("busy_addr", mem_addr, addr);
        if (wr) check_val("busy_wdata", mem_wdata, wd);
        // Inputs are free to change once the access has started.
        PC = $urandom; ALUOut = $urandom; WriteData = $urandom;
        IorD = 1'($urandom); IRWrite = 1'($urandom);
        if (!hold) begin MemRead = 0; MemWrite = 0; end
        stall_cnt = 1;
        c = 1;
        while (mem_stall === 1'b1 && c <= 40) begin
            stall_cnt++;
            if (c == ack_k) begin mem_ack = 1; mem_rdata = rdata; end
            tick();
            mem_ack = 0;
            mem_rdata = $urandom;
            c++;
        end
        if (ack_k >= 1 && ack_k <= TO) begin
            exp_stall = ack_k + 1;
            if (!wr) begin
                if (irw) exp_ir = rdata;
                else     exp_mdr = rdata;
            end
        end else begin
            exp_stall = TO + 1;
            exp_err = 1'b1;
        end
        check_val("stall_len", stall_cnt, exp_stall);
        check_val("done_req", mem_req, 0);
        check_val("done_stall", mem_stall, 0);
        check_val("done_ir", Instruction, exp_ir);
        check_val("done_mdr", MemData, exp_mdr);
        check_val("done_err", bus_err, exp_err);
        check_val("done_addr_kept", mem_addr, addr);
        tick();
        if (hold) begin
            check_val("no_req_from_done", mem_req, 0);
            MemRead = 0; MemWrite = 0;
            tick();
            check_val("no_req_after_drop", mem_req, 0);
        end
        $display("txn rd=%0b wr=%0b dst=%0b addr=%h ack_k=%0d stall=%0d ir=%h mdr=%h err=%0b",
                 rd, wr, irw, addr, ack_k, stall_cnt, Instruction, MemData, bus_err);
    endtask

    initial begin
        reset = 0; MemRead = 0; MemWrite = 0; IRWrite = 0; IorD = 0;
        PC = 0; ALUOut = 0; WriteData = 0; mem_rdata = 0; mem_ack = 0;
        exp_ir = 0; exp_mdr = 0; exp_err = 0;
        repeat (3) tick();
        check_val("rst_req", mem_req, 0);
        check_val("rst_we", mem_we, 0);
        check_val("rst_addr", mem_addr, 0);
        check_val("rst_wdata", mem_wdata, 0);
        check_val("rst_ir", Instruction, 0);
        check_val("rst_mdr", MemData, 0);
        check_val("rst_err", bus_err, 0);
        check_val("rst_stall", mem_stall, 0);
        reset = 1;
        tick();

        // Fetch, ack in BUSY cycle 3
        run_access(1, 0, 1, 0, 32'h0040_0004, 32'h0, 32'h0, 3, 32'h2008_0005, 0);
        // Store, ack in BUSY cycle 1
        run_access(0, 1, 0, 1, 32'h0, 32'h1000_0010, 32'hDEAD_BEEF, 1, 32'h5555_5555, 0);
        // Load to MDR
        run_access(1, 0, 0, 1, 32'h0, 32'h1000_0020, 32'h0, 5, 32'h1234_5678, 0);
        // Ack in the last permitted cycle
        run_access(1, 0, 0, 1, 32'h0, 32'h1000_0024, 32'h0, TO, 32'hCAFE_0001, 0);
        // Back-to-back strobes held through DONE
        run_access(1, 0, 1, 0, 32'h0040_0008, 32'h0, 32'h0, 2, 32'h8C01_0000, 1);
        // Ack while idle must be ignored
        mem_ack = 1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        mem_ack = 0;
        check_val("idle_ack_ir", Instruction, exp_ir);
        check_val("idle_ack_mdr", MemData, exp_mdr);
        check_val("idle_ack_req", mem_req, 0);
        // Timeout (sets sticky error)
        run_access(1, 0, 0, 0, 32'h0040_0010, 32'h0, 32'h0, 0, 32'h0, 0);
        // Both strobes, then a misaligned load
        run_access(1, 1, 0, 0, 32'h0040_0000, 32'h0, 32'h0, 1, 32'h0, 0);
        run_access(1, 0, 0, 1, 32'h0, 32'h1000_0002, 32'h0, 1, 32'h0, 0);

        // Reset in BUSY cycle 2, then a late ack
        MemRead = 1; IRWrite = 1; IorD = 0; PC = 32'h0040_0020;
        tick();
        MemRead = 0;
        tick();
        reset = 0;
        tick();
        reset = 1;
        exp_ir = 0; exp_mdr = 0; exp_err = 0;
        check_val("midrst_req", mem_req, 0);
        check_val("midrst_ir", Instruction, 0);
        check_val("midrst_mdr", MemData, 0);
        check_val("midrst_err", bus_err, 0);
        check_val("midrst_stall", mem_stall, 0);
        mem_ack = 1; mem_rdata = 32'hFFFF_0000;
        tick();
        mem_ack = 0;
        check_val("late_ack_ir", Instruction, 0);
        check_val("late_ack_mdr", MemData, 0);
        check_val("late_ack_req", mem_req, 0);
        $display("txn reset mid-busy ir=%h mdr=%h req=%0b", Instruction, MemData, mem_req);

        // Random transactions
        for (int i = 0; i < 60; i++) begin
            bit          rd, wr, irw, iord, hold;
            logic [31:0] pc, alu;
            int          k;
            rd   = ($urandom_range(0, 9) < 6);
            wr   = ($urandom_range(0, 9) < (rd ? 1 : 6));
            irw  = 1'($urandom);
            iord = 1'($urandom);
            hold = ($urandom_range(0, 4) == 0);
            pc   = $urandom & ~32'h3;
            alu  = $urandom & ~32'h3;
            if ($urandom_range(0, 7) == 0) alu = alu | 32'($urandom_range(1, 3));
            k    = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, TO);
            if ($urandom_range(0, 5) == 0) begin
                mem_ack = 1; mem_rdata = $urandom;
                tick();
                mem_ack = 0;
                check_val("rand_idle_ack_ir", Instruction, exp_ir);
                check_val("rand_idle_ack_mdr", MemData, exp_mdr);
            end
            run_access(rd, wr, irw, iord, pc, alu, $urandom, k, $urandom, hold);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
